// File: rtl/snake_body_engine_if.sv
// Command/status bundle between the game FSM (master) and the snake body engine (slave).
// Also carries the render stream toward the LED-matrix renderer.
interface snake_body_engine_if #(
    parameter int unsigned GRID_W  = 4,
    parameter int unsigned GRID_H  = 4,
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned PW = $clog2(GRID_W * GRID_H);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    logic          start;
    logic          step;
    logic [1:0]    dir;
    logic [PW-1:0] apple_pos;
    logic          apple_valid;
    logic          render_req;
    logic          busy;
    logic          step_done;
    logic          ate_apple;
    logic          game_over;
    logic          win;
    logic [LW-1:0] size;
    logic [PW-1:0] head_pos;
    logic          render_valid;
    logic [PW-1:0] render_pos;
    logic          render_last;

    modport master (
        output start, step, dir, apple_pos, apple_valid, render_req,
        input  busy, step_done, ate_apple, game_over, win, size, head_pos,
               render_valid, render_pos, render_last
    );

    modport slave (
        input  start, step, dir, apple_pos, apple_valid, render_req,
        output busy, step_done, ate_apple, game_over, win, size, head_pos,
               render_valid, render_pos, render_last
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body held in a circular buffer: steps the head, scans for self collision,
// grows on apple capture and streams the body to the renderer one segment per cycle.
module snake_body_engine #(
    parameter int unsigned GRID_W    = 4,
    parameter int unsigned GRID_H    = 4,
    parameter int unsigned MAX_LEN   = 16,
    parameter bit          WRAP      = 1'b0,
    parameter int unsigned START_POS = 5
) (
    input  logic               clock,
    input  logic               restart_n,
    snake_body_engine_if.slave bus
);
    localparam int unsigned PW = $clog2(GRID_W * GRID_H);
    localparam int unsigned XW = $clog2(GRID_W);
    localparam int unsigned YW = $clog2(GRID_H);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned SW = LW + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] MOVE   = 3'd2;
    localparam logic [2:0] DEAD   = 3'd3;
    localparam logic [2:0] RENDER = 3'd4;

    logic [PW-1:0] buf_q [MAX_LEN];
    logic [2:0]    state_q, state_d;
    logic [AW-1:0] hp_q, hp_d, hp_inc, seg_idx;
    logic [LW-1:0] size_q, size_d, k_q, k_d, cnt;
    logic [1:0]    cur_dir_q, cur_dir_d, eff_dir;
    logic [PW-1:0] nxt_q, nxt_d, head, seg, nxt;
    logic          grow_q, grow_d, win_q, win_d;
    logic [XW-1:0] hx, nx;
    logic [YW-1:0] hy, ny;
    logic [SW-1:0] idx_sum;
    logic          wall, match, last;

    assign head    = buf_q[hp_q];
    assign hx      = head[XW-1:0];
    assign hy      = head[PW-1:XW];
    assign nxt     = {ny, nx};
    assign hp_inc  = (hp_q == AW'(MAX_LEN - 1)) ? '0 : hp_q + AW'(1);
    // Segment k sits k slots behind the write pointer, modulo a possibly non-power-of-2 depth.
    assign idx_sum = SW'(hp_q) + SW'(MAX_LEN) - SW'(k_q);
    assign seg_idx = (idx_sum >= SW'(MAX_LEN)) ? AW'(idx_sum - SW'(MAX_LEN)) : AW'(idx_sum);
    assign seg     = buf_q[seg_idx];
    // The tail vacates its cell on a plain move, so it only counts when growing.
    assign cnt     = grow_q ? size_q : size_q - LW'(1);
    assign match   = (k_q < cnt) && (seg == nxt_q);
    assign last    = (SW'(k_q) + SW'(1)) >= SW'(cnt);

    always_comb begin
        eff_dir = bus.dir;
        if (size_q > LW'(1) && bus.dir == (cur_dir_q ^ 2'b01)) eff_dir = cur_dir_q;
        nx   = hx;
        ny   = hy;
        wall = 1'b0;
        unique case (eff_dir)
            2'b00: begin wall = (hy == '0);               ny = hy - YW'(1); end
            2'b01: begin wall = (hy == YW'(GRID_H - 1));  ny = hy + YW'(1); end
            2'b10: begin wall = (hx == '0);               nx = hx - XW'(1); end
            default: begin wall = (hx == XW'(GRID_W - 1)); nx = hx + XW'(1); end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hp_d      = hp_q;
        size_d    = size_q;
        k_d       = k_q;
        cur_dir_d = cur_dir_q;
        nxt_d     = nxt_q;
        grow_d    = grow_q;
        win_d     = win_q;
        case (state_q)
            IDLE: begin
                if (bus.step && !win_q) begin
                    nxt_d     = nxt;
                    grow_d    = bus.apple_valid && (nxt == bus.apple_pos);
                    cur_dir_d = eff_dir;
                    k_d       = '0;
                    state_d   = (wall && !WRAP) ? DEAD : CHECK;
                end else if (bus.render_req) begin
                    k_d     = '0;
                    state_d = RENDER;
                end
            end
            CHECK: begin
                if (match)     state_d = DEAD;
                else if (last) state_d = MOVE;
                else           k_d = k_q + LW'(1);
            end
            MOVE: begin
                hp_d = hp_inc;
                if (grow_q && size_q < LW'(MAX_LEN)) begin
                    size_d = size_q + LW'(1);
                    if (size_d == LW'(MAX_LEN)) win_d = 1'b1;
                end
                state_d = IDLE;
            end
            DEAD: state_d = DEAD;
            RENDER: begin
                if (k_q == size_q - LW'(1)) state_d = IDLE;
                else                        k_d = k_q + LW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (bus.start) begin
            state_d   = IDLE;
            size_d    = LW'(1);
            hp_d      = hp_q;
            cur_dir_d = 2'b11;
            win_d     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!restart_n) begin
            state_q   <= IDLE;
            hp_q      <= '0;
            size_q    <= LW'(1);
            k_q       <= '0;
            cur_dir_q <= 2'b11;
            nxt_q     <= '0;
            grow_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_q      <= hp_d;
            size_q    <= size_d;
            k_q       <= k_d;
            cur_dir_q <= cur_dir_d;
            nxt_q     <= nxt_d;
            grow_q    <= grow_d;
            win_q     <= win_d;
        end
    end

    // Body storage is not cleared; only the head slot is seeded on init.
    always_ff @(posedge clock) begin
        if (!restart_n)              buf_q[0]    <= PW'(START_POS);
        else if (bus.start)          buf_q[hp_q] <= PW'(START_POS);
        else if (state_q == MOVE)    buf_q[hp_d] <= nxt_q;
    end

    assign bus.busy         = (state_q != IDLE) && (state_q != DEAD);
    assign bus.step_done    = (state_q == MOVE);
    assign bus.ate_apple    = (state_q == MOVE) && grow_q;
    assign bus.game_over    = (state_q == DEAD);
    assign bus.win          = win_q;
    assign bus.size         = size_q;
    assign bus.head_pos     = head;
    assign bus.render_valid = (state_q == RENDER);
    assign bus.render_pos   = seg;
    assign bus.render_last  = (state_q == RENDER) && (k_q == size_q - LW'(1));
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench: a default 4x4/16 engine plus a wrapping 4x4 engine with a 4-deep buffer.
module tb_snake_body_engine;
    logic clk = 1'b0;
    logic restart_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    snake_body_engine_if #(.GRID_W(4), .GRID_H(4), .MAX_LEN(16)) a_if ();
    snake_body_engine_if #(.GRID_W(4), .GRID_H(4), .MAX_LEN(4))  w_if ();

    snake_body_engine #(.GRID_W(4), .GRID_H(4), .MAX_LEN(16), .WRAP(1'b0), .START_POS(5)) u_a (
        .clock(clk), .restart_n(restart_n), .bus(a_if)
    );
    snake_body_engine #(.GRID_W(4), .GRID_H(4), .MAX_LEN(4), .WRAP(1'b1), .START_POS(5)) u_w (
        .clock(clk), .restart_n(restart_n), .bus(w_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one step and waits (bounded) until it commits or the snake dies.
    task automatic move(input bit on_w, input logic [1:0] d, input logic [3:0] ap,
                        input logic av);
        bit seen = 1'b0;
        if (on_w) begin
            w_if.dir = d; w_if.apple_pos = ap; w_if.apple_valid = av; w_if.step = 1'b1;
        end else begin
            a_if.dir = d; a_if.apple_pos = ap; a_if.apple_valid = av; a_if.step = 1'b1;
        end
        tick();
        a_if.step = 1'b0;
        w_if.step = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (on_w ? (w_if.step_done || w_if.game_over) : (a_if.step_done || a_if.game_over))
                seen = 1'b1;
            else
                tick();
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL move_timeout got no step_done/game_over want one within 40 cycles");
        end
        tick();
        a_if.apple_valid = 1'b0;
        w_if.apple_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit on_w);
        if (on_w) w_if.start = 1'b1; else a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        w_if.start = 1'b0;
    endtask

    task automatic test_reset();
        restart_n = 1'b0;
        tick();
        restart_n = 1'b1;
        checks++; if (a_if.size !== 5'd1) begin errors++; $display("FAIL reset_size got %0d want 1", a_if.size); end
        checks++; if (a_if.head_pos !== 4'd5) begin errors++; $display("FAIL reset_head got %0d want 5", a_if.head_pos); end
        checks++; if (a_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_if.busy); end
        checks++; if (a_if.game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b want 0", a_if.game_over); end
        checks++; if (a_if.win !== 1'b0) begin errors++; $display("FAIL reset_win got %b want 0", a_if.win); end
        checks++; if (w_if.head_pos !== 4'd5) begin errors++; $display("FAIL reset_head_w got %0d want 5", w_if.head_pos); end
    endtask

    task automatic test_step();
        a_if.dir = 2'b11; a_if.apple_valid = 1'b0; a_if.step = 1'b1;
        tick();
        a_if.step = 1'b0;
        checks++; if (a_if.busy !== 1'b1 || a_if.step_done !== 1'b0) begin errors++; $display("FAIL step_c1 got busy=%b done=%b want 1 0", a_if.busy, a_if.step_done); end
        tick();
        checks++; if (a_if.step_done !== 1'b1 || a_if.ate_apple !== 1'b0) begin errors++; $display("FAIL step_c2 got done=%b ate=%b want 1 0", a_if.step_done, a_if.ate_apple); end
        tick();
        checks++; if (a_if.head_pos !== 4'd6 || a_if.size !== 5'd1 || a_if.busy !== 1'b0) begin errors++; $display("FAIL step_c3 got head=%0d size=%0d busy=%b want 6 1 0", a_if.head_pos, a_if.size, a_if.busy); end
    endtask

    task automatic test_grow_render();
        a_if.dir = 2'b11; a_if.apple_pos = 4'd7; a_if.apple_valid = 1'b1; a_if.step = 1'b1;
        tick();
        a_if.step = 1'b0;
        tick();
        checks++; if (a_if.step_done !== 1'b1 || a_if.ate_apple !== 1'b1) begin errors++; $display("FAIL grow_pulse got done=%b ate=%b want 1 1", a_if.step_done, a_if.ate_apple); end
        tick();
        a_if.apple_valid = 1'b0;
        checks++; if (a_if.size !== 5'd2 || a_if.head_pos !== 4'd7 || a_if.ate_apple !== 1'b0) begin errors++; $display("FAIL grow_state got size=%0d head=%0d ate=%b want 2 7 0", a_if.size, a_if.head_pos, a_if.ate_apple); end
        a_if.render_req = 1'b1;
        tick();
        a_if.render_req = 1'b0;
        checks++; if (a_if.render_valid !== 1'b1 || a_if.render_pos !== 4'd7 || a_if.render_last !== 1'b0) begin errors++; $display("FAIL render_seg0 got v=%b pos=%0d last=%b want 1 7 0", a_if.render_valid, a_if.render_pos, a_if.render_last); end
        tick();
        checks++; if (a_if.render_valid !== 1'b1 || a_if.render_pos !== 4'd6 || a_if.render_last !== 1'b1) begin errors++; $display("FAIL render_seg1 got v=%b pos=%0d last=%b want 1 6 1", a_if.render_valid, a_if.render_pos, a_if.render_last); end
        tick();
        checks++; if (a_if.render_valid !== 1'b0 || a_if.busy !== 1'b0) begin errors++; $display("FAIL render_end got v=%b busy=%b want 0 0", a_if.render_valid, a_if.busy); end
    endtask

    task automatic test_wall();
        a_if.dir = 2'b11; a_if.step = 1'b1;
        tick();
        a_if.step = 1'b0;
        checks++; if (a_if.game_over !== 1'b1 || a_if.busy !== 1'b0) begin errors++; $display("FAIL wall_c1 got go=%b busy=%b want 1 0", a_if.game_over, a_if.busy); end
        a_if.dir = 2'b00; a_if.step = 1'b1;
        tick();
        a_if.step = 1'b0;
        tick();
        checks++; if (a_if.game_over !== 1'b1 || a_if.head_pos !== 4'd7 || a_if.step_done !== 1'b0) begin errors++; $display("FAIL dead_ignore got go=%b head=%0d done=%b want 1 7 0", a_if.game_over, a_if.head_pos, a_if.step_done); end
        pulse_start(1'b0);
        checks++; if (a_if.game_over !== 1'b0 || a_if.size !== 5'd1 || a_if.head_pos !== 4'd5) begin errors++; $display("FAIL start_clear got go=%b size=%0d head=%0d want 0 1 5", a_if.game_over, a_if.size, a_if.head_pos); end
    endtask

    task automatic test_self_hit();
        move(1'b0, 2'b11, 4'd6, 1'b1);
        move(1'b0, 2'b11, 4'd7, 1'b1);
        move(1'b0, 2'b01, 4'd11, 1'b1);
        move(1'b0, 2'b10, 4'd10, 1'b1);
        checks++; if (a_if.size !== 5'd5 || a_if.head_pos !== 4'd10) begin errors++; $display("FAIL self_setup got size=%0d head=%0d want 5 10", a_if.size, a_if.head_pos); end
        a_if.dir = 2'b00; a_if.apple_valid = 1'b0; a_if.step = 1'b1;
        tick();
        a_if.step = 1'b0;
        tick(); tick(); tick();
        checks++; if (a_if.game_over !== 1'b0 || a_if.busy !== 1'b1) begin errors++; $display("FAIL self_c4 got go=%b busy=%b want 0 1", a_if.game_over, a_if.busy); end
        tick();
        checks++; if (a_if.game_over !== 1'b1) begin errors++; $display("FAIL self_c5 got go=%b want 1", a_if.game_over); end
        pulse_start(1'b0);
    endtask

    task automatic test_tail_move();
        move(1'b0, 2'b11, 4'd6, 1'b1);
        move(1'b0, 2'b01, 4'd10, 1'b1);
        move(1'b0, 2'b10, 4'd9, 1'b1);
        checks++; if (a_if.size !== 5'd4 || a_if.head_pos !== 4'd9) begin errors++; $display("FAIL tail_setup got size=%0d head=%0d want 4 9", a_if.size, a_if.head_pos); end
        a_if.dir = 2'b00; a_if.apple_valid = 1'b0; a_if.step = 1'b1;
        tick();
        a_if.step = 1'b0;
        tick(); tick();
        checks++; if (a_if.step_done !== 1'b0) begin errors++; $display("FAIL tail_c3 got done=%b want 0", a_if.step_done); end
        tick();
        checks++; if (a_if.step_done !== 1'b1) begin errors++; $display("FAIL tail_c4 got done=%b want 1", a_if.step_done); end
        tick();
        checks++; if (a_if.head_pos !== 4'd5 || a_if.size !== 5'd4 || a_if.game_over !== 1'b0) begin errors++; $display("FAIL tail_c5 got head=%0d size=%0d go=%b want 5 4 0", a_if.head_pos, a_if.size, a_if.game_over); end
    endtask

    task automatic test_reverse();
        move(1'b0, 2'b01, 4'd0, 1'b0);
        checks++; if (a_if.head_pos !== 4'd1 || a_if.game_over !== 1'b0) begin errors++; $display("FAIL reverse got head=%0d go=%b want 1 0", a_if.head_pos, a_if.game_over); end
    endtask

    task automatic test_start_mid_check();
        a_if.dir = 2'b11; a_if.step = 1'b1;
        tick();
        a_if.step = 1'b0;
        checks++; if (a_if.busy !== 1'b1) begin errors++; $display("FAIL midcheck_busy got %b want 1", a_if.busy); end
        pulse_start(1'b0);
        checks++; if (a_if.busy !== 1'b0 || a_if.size !== 5'd1 || a_if.head_pos !== 4'd5) begin errors++; $display("FAIL midcheck_abort got busy=%b size=%0d head=%0d want 0 1 5", a_if.busy, a_if.size, a_if.head_pos); end
        tick();
        checks++; if (a_if.step_done !== 1'b0) begin errors++; $display("FAIL midcheck_no_done got %b want 0", a_if.step_done); end
    endtask

    task automatic test_wrap();
        move(1'b1, 2'b11, 4'd0, 1'b0);
        move(1'b1, 2'b11, 4'd0, 1'b0);
        checks++; if (w_if.head_pos !== 4'd7) begin errors++; $display("FAIL wrap_pre got head=%0d want 7", w_if.head_pos); end
        move(1'b1, 2'b11, 4'd0, 1'b0);
        checks++; if (w_if.head_pos !== 4'd4 || w_if.game_over !== 1'b0 || w_if.size !== 3'd1) begin errors++; $display("FAIL wrap_edge got head=%0d go=%b size=%0d want 4 0 1", w_if.head_pos, w_if.game_over, w_if.size); end
    endtask

    task automatic test_win();
        logic [3:0] exp_seg [4];
        exp_seg[0] = 4'd4; exp_seg[1] = 4'd7; exp_seg[2] = 4'd6; exp_seg[3] = 4'd5;
        pulse_start(1'b1);
        move(1'b1, 2'b11, 4'd6, 1'b1);
        move(1'b1, 2'b11, 4'd7, 1'b1);
        checks++; if (w_if.size !== 3'd3 || w_if.win !== 1'b0) begin errors++; $display("FAIL win_pre got size=%0d win=%b want 3 0", w_if.size, w_if.win); end
        move(1'b1, 2'b11, 4'd4, 1'b1);
        checks++; if (w_if.size !== 3'd4 || w_if.win !== 1'b1 || w_if.head_pos !== 4'd4) begin errors++; $display("FAIL win_set got size=%0d win=%b head=%0d want 4 1 4", w_if.size, w_if.win, w_if.head_pos); end
        w_if.dir = 2'b11; w_if.step = 1'b1;
        tick();
        w_if.step = 1'b0;
        checks++; if (w_if.busy !== 1'b0) begin errors++; $display("FAIL win_ignore_busy got %b want 0", w_if.busy); end
        tick();
        checks++; if (w_if.head_pos !== 4'd4 || w_if.step_done !== 1'b0) begin errors++; $display("FAIL win_ignore got head=%0d done=%b want 4 0", w_if.head_pos, w_if.step_done); end
        w_if.render_req = 1'b1;
        tick();
        w_if.render_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_if.render_valid !== 1'b1 || w_if.render_pos !== exp_seg[i] ||
                w_if.render_last !== (i == 3)) begin
                errors++;
                $display("FAIL win_render[%0d] got v=%b pos=%0d last=%b want 1 %0d %b", i,
                         w_if.render_valid, w_if.render_pos, w_if.render_last, exp_seg[i], i == 3);
            end
            tick();
        end
        checks++; if (w_if.render_valid !== 1'b0) begin errors++; $display("FAIL win_render_end got v=%b want 0", w_if.render_valid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.start = 1'b0; a_if.step = 1'b0; a_if.dir = 2'b11; a_if.apple_pos = '0;
        a_if.apple_valid = 1'b0; a_if.render_req = 1'b0;
        w_if.start = 1'b0; w_if.step = 1'b0; w_if.dir = 2'b11; w_if.apple_pos = '0;
        w_if.apple_valid = 1'b0; w_if.render_req = 1'b0;
        #2;
        test_reset();
        test_step();
        test_grow_render();
        test_wall();
        test_self_hit();
        test_tail_move();
        test_reverse();
        test_start_mid_check();
        test_wrap();
        test_win();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
